// File: rtl/motor_enable_sequencer.sv
// -----------------------------------------------------------------------------
// motor_enable_sequencer
//   Enable sequencer for two H-bridge motor drivers. It runs the bridges on
//   request, debounces an overcurrent sense into trips, and enforces a
//   cooldown after each trip. A trip that reaches MAX_TRIPS latches a
//   lockout, which only clear_fault (or reset) releases. An uninterrupted
//   healthy run of HEALTHY_CYC cycles forgives earlier trips.
//
// Build option:
//   MOTOR_STAGGER_EN - when defined, enB is held off for STAGGER_CYC cycles
//                      after RUN entry to spread inrush current. When it is
//                      not defined, enB simply follows req_b in RUN.
//
// Ports:
//   clk          in   rising-edge clock for all logic
//   rst          in   synchronous active-high reset
//   req_a/req_b  in   drive requests for motors A and B
//   oc_trip      in   asynchronous overcurrent sense (synchronized here)
//   clear_fault  in   single-cycle pulse that releases LOCKOUT
//   enA/enB      out  registered H-bridge enables
//   fault        out  high while in LOCKOUT
//   state        out  IDLE=0, RUN=1, COOLDOWN=2, LOCKOUT=3
//   trip_cnt     out  trips since the last clear
// -----------------------------------------------------------------------------
module motor_enable_sequencer #(
   parameter int unsigned DEBOUNCE_CYC = 32'd40000000,
   parameter int unsigned COOL_CYC     = 32'd300000000,
   parameter int unsigned HEALTHY_CYC  = 32'd100000000,
   parameter int unsigned MAX_TRIPS    = 32'd3,
   parameter int unsigned STAGGER_CYC  = 32'd5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       oc_trip,
   input  logic       clear_fault,
   output logic       enA,
   output logic       enB,
   output logic       fault,
   output logic [1:0] state,
   output logic [3:0] trip_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      COOLDOWN = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;

   state_t      cur;
   state_t      nxt;
   logic        oc_meta;
   logic        oc_s;
   logic        trip;
   logic [31:0] deb_cnt;
   logic [31:0] deb_nxt;
   logic [31:0] cool_cnt;
   logic [31:0] cool_nxt;
   logic [31:0] healthy_cnt;
   logic [31:0] healthy_nxt;
   logic [3:0]  trip_nxt;
   logic        fault_nxt;
   logic        ena_nxt;
   logic        enb_nxt;

   assign state = cur;

   // Two-flop synchronizer for the asynchronous overcurrent sense.
   always_ff @(posedge clk) begin
      if (rst) begin
         oc_meta <= 1'b0;
         oc_s    <= 1'b0;
      end else begin
         oc_meta <= oc_trip;
         oc_s    <= oc_meta;
      end
   end

   // Next-state, counter and status decode.
   always_comb begin
      nxt         = cur;
      trip        = 1'b0;
      deb_nxt     = 32'd0;
      cool_nxt    = 32'd0;
      healthy_nxt = 32'd0;
      trip_nxt    = trip_cnt;
      fault_nxt   = fault;
      case (cur)
         IDLE: begin
            if (req_a | req_b) begin
               nxt = RUN;
            end else begin
               nxt = IDLE;
            end
         end
         RUN: begin
            trip = oc_s && (deb_cnt == DEBOUNCE_CYC - 32'd1);
            if (trip) begin
               // A trip beats a simultaneous request drop or healthy clear.
               if (trip_cnt == 4'(MAX_TRIPS - 32'd1)) begin
                  nxt       = LOCKOUT;
                  trip_nxt  = 4'(MAX_TRIPS);
                  fault_nxt = 1'b1;
               end else begin
                  nxt      = COOLDOWN;
                  trip_nxt = trip_cnt + 4'd1;
               end
            end else begin
               // Healthy counter saturates at its threshold and keeps the
               // trip count cleared for as long as RUN continues.
               if (healthy_cnt >= HEALTHY_CYC - 32'd1) begin
                  healthy_nxt = healthy_cnt;
                  trip_nxt    = 4'd0;
               end else begin
                  healthy_nxt = healthy_cnt + 32'd1;
               end
               if (oc_s) begin
                  deb_nxt = deb_cnt + 32'd1;
               end else begin
                  deb_nxt = 32'd0;
               end
               if (req_a | req_b) begin
                  nxt = RUN;
               end else begin
                  nxt = IDLE;
               end
            end
         end
         COOLDOWN: begin
            if (cool_cnt >= COOL_CYC - 32'd1) begin
               nxt = IDLE;
            end else begin
               cool_nxt = cool_cnt + 32'd1;
            end
         end
         LOCKOUT: begin
            if (clear_fault) begin
               nxt       = IDLE;
               fault_nxt = 1'b0;
               trip_nxt  = 4'd0;
            end else begin
               nxt = LOCKOUT;
            end
         end
         default: begin
            nxt = IDLE;
         end
      endcase
      // Run-scoped counters restart whenever RUN is left.
      if (nxt != RUN) begin
         deb_nxt     = 32'd0;
         healthy_nxt = 32'd0;
      end else begin
         deb_nxt     = deb_nxt;
         healthy_nxt = healthy_nxt;
      end
   end

   // Enable A follows its request only while the next state is RUN, so a
   // trip or exit drops it on the same edge.
   always_comb begin
      ena_nxt = 1'b0;
      if (nxt == RUN) begin
         ena_nxt = req_a;
      end else begin
         ena_nxt = 1'b0;
      end
   end

`ifdef MOTOR_STAGGER_EN
   logic [31:0] stg_cnt;
   logic [31:0] stg_nxt;

   // Stagger counter: zero on RUN entry, saturating at STAGGER_CYC.
   always_comb begin
      stg_nxt = 32'd0;
      enb_nxt = 1'b0;
      if ((cur == RUN) && (nxt == RUN)) begin
         if (stg_cnt >= STAGGER_CYC) begin
            stg_nxt = stg_cnt;
         end else begin
            stg_nxt = stg_cnt + 32'd1;
         end
      end else begin
         stg_nxt = 32'd0;
      end
      if ((nxt == RUN) && (stg_nxt >= STAGGER_CYC)) begin
         enb_nxt = req_b;
      end else begin
         enb_nxt = 1'b0;
      end
   end

   // Stagger counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_cnt <= 32'd0;
      end else begin
         stg_cnt <= stg_nxt;
      end
   end
`else
   logic unused_stagger;
   assign unused_stagger = ^STAGGER_CYC;

   // Enable B follows its request directly while the next state is RUN.
   always_comb begin
      enb_nxt = 1'b0;
      if (nxt == RUN) begin
         enb_nxt = req_b;
      end else begin
         enb_nxt = 1'b0;
      end
   end
`endif

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur         <= IDLE;
         deb_cnt     <= 32'd0;
         cool_cnt    <= 32'd0;
         healthy_cnt <= 32'd0;
         trip_cnt    <= 4'd0;
         fault       <= 1'b0;
         enA         <= 1'b0;
         enB         <= 1'b0;
      end else begin
         cur         <= nxt;
         deb_cnt     <= deb_nxt;
         cool_cnt    <= cool_nxt;
         healthy_cnt <= healthy_nxt;
         trip_cnt    <= trip_nxt;
         fault       <= fault_nxt;
         enA         <= ena_nxt;
         enB         <= enb_nxt;
      end
   end

endmodule

// File: tb/tb_motor_enable_sequencer.sv
// -----------------------------------------------------------------------------
// tb_motor_enable_sequencer
//   Directed scenarios followed by randomized traffic. A timestamp-based
//   reference model predicts every output after each rising edge.
// -----------------------------------------------------------------------------
module tb_motor_enable_sequencer;

   localparam int D   = 4;
   localparam int CL  = 10;
   localparam int H   = 20;
   localparam int MX  = 3;
   localparam int STG = 3;
`ifdef MOTOR_STAGGER_EN
   localparam bit STAGGER_ON = 1'b1;
`else
   localparam bit STAGGER_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic       oc_trip = 1'b0;
   logic       clear_fault = 1'b0;
   logic       enA;
   logic       enB;
   logic       fault;
   logic [1:0] state;
   logic [3:0] trip_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: timestamps instead of counters
   int cyc = 0;
   int m_state = 0;
   int m_trips = 0;
   int m_fault = 0;
   int m_ena = 0;
   int m_enb = 0;
   int oc_hist[2] = '{0, 0};   // [0] = sampled last edge, [1] = two edges ago
   int oc_streak = 0;          // consecutive synchronized-high RUN edges
   int run_start = 0;
   int cool_end = 0;

   always #5 clk = ~clk;

   motor_enable_sequencer #(
      .DEBOUNCE_CYC(D), .COOL_CYC(CL), .HEALTHY_CYC(H),
      .MAX_TRIPS(MX), .STAGGER_CYC(STG)
   ) dut (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
      .oc_trip(oc_trip), .clear_fault(clear_fault),
      .enA(enA), .enB(enB), .fault(fault), .state(state), .trip_cnt(trip_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_edge();
      int  oc_now;
      int  nxt;
      bit  tripped;
      if (rst) begin
         m_state = 0; m_trips = 0; m_fault = 0; m_ena = 0; m_enb = 0;
         oc_hist = '{0, 0}; oc_streak = 0;
      end else begin
         oc_now  = oc_hist[1];
         oc_hist[1] = oc_hist[0];
         oc_hist[0] = int'(oc_trip);
         nxt = m_state;
         tripped = 1'b0;
         case (m_state)
            0: if (req_a || req_b) begin nxt = 1; run_start = cyc; end
            1: begin
               tripped = (oc_now == 1) && (oc_streak == D - 1);
               if (tripped) begin
                  if (m_trips == MX - 1) begin
                     nxt = 3; m_trips = MX; m_fault = 1;
                  end else begin
                     nxt = 2; m_trips++; cool_end = cyc + CL;
                  end
               end else begin
                  if (cyc - run_start >= H) m_trips = 0;
                  if (!req_a && !req_b) nxt = 0;
               end
               oc_streak = (oc_now == 1 && !tripped) ? oc_streak + 1 : 0;
            end
            2: if (cyc == cool_end) nxt = 0;
            default: if (clear_fault) begin nxt = 0; m_fault = 0; m_trips = 0; end
         endcase
         if (nxt != 1) oc_streak = 0;
         m_state = nxt;
         m_ena = (nxt == 1 && req_a) ? 1 : 0;
         m_enb = (nxt == 1 && req_b && (!STAGGER_ON || (cyc - run_start >= STG))) ? 1 : 0;
      end
      cyc++;
   endtask

   // One clock: edge, model update, compare all outputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("state", 32'(state), 32'(m_state));
      chk("enA", 32'(enA), 32'(m_ena));
      chk("enB", 32'(enB), 32'(m_enb));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("trip_cnt", 32'(trip_cnt), 32'(m_trips));
   endtask

   task automatic do_trip();
      oc_trip = 1'b1;
      repeat (6) step();
      oc_trip = 1'b0;
   endtask

   int oc_left = 0;

   initial begin
      // Reset
      repeat (2) step();
      rst = 1'b0;
      step();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_en", 32'({enA, enB}), 32'd0);
      chk("rst_trips", 32'(trip_cnt), 32'd0);

      // Both requests: enA next edge, enB staggered by STG
      req_a = 1'b1; req_b = 1'b1;
      step();
      chk("t035_enA", 32'(enA), 32'd1);
      chk("t035_enB_early", 32'(enB), STAGGER_ON ? 32'd0 : 32'd1);
      repeat (STG) step();
      chk("t035_enB", 32'(enB), 32'd1);

      // Short overcurrent pulses do not trip
      repeat (3) begin
         oc_trip = 1'b1; repeat (3) step();
         oc_trip = 1'b0; step();
      end
      repeat (3) step();
      chk("t037_state", 32'(state), 32'd1);
      chk("t037_en", 32'({enA, enB}), 32'd3);

      // Sustained overcurrent: trip at the 6th edge
      oc_trip = 1'b1;
      repeat (5) step();
      chk("t036_pre", 32'(enA), 32'd1);
      step();
      chk("t036_state", 32'(state), 32'd2);
      chk("t036_en", 32'({enA, enB}), 32'd0);
      chk("t036_trips", 32'(trip_cnt), 32'd1);
      oc_trip = 1'b0;
      repeat (CL - 1) step();
      chk("t036_cool", 32'(state), 32'd2);
      step();
      chk("t036_idle", 32'(state), 32'd0);

      // Two more trips lead to lockout
      step();
      do_trip();
      chk("t038_trip2", 32'(trip_cnt), 32'd2);
      repeat (CL + 1) step();
      do_trip();
      chk("t038_state", 32'(state), 32'd3);
      chk("t038_fault", 32'(fault), 32'd1);
      chk("t038_trips", 32'(trip_cnt), 32'd3);
      repeat (5) step();
      chk("t038_hold", 32'(state), 32'd3);
      chk("t038_hold_en", 32'({enA, enB}), 32'd0);
      clear_fault = 1'b1; step(); clear_fault = 1'b0;
      chk("t038_clr_state", 32'(state), 32'd0);
      chk("t038_clr_trips", 32'(trip_cnt), 32'd0);

      // One trip, then a healthy run clears the count
      step();
      do_trip();
      repeat (CL + 1) step();
      chk("t039_run", 32'(state), 32'd1);
      repeat (H - 1) step();
      chk("t039_before", 32'(trip_cnt), 32'd1);
      step();
      chk("t039_after", 32'(trip_cnt), 32'd0);

      // Reset while locked out with overcurrent present
      do_trip(); repeat (CL + 1) step();
      do_trip(); repeat (CL + 1) step();
      do_trip();
      chk("t040_lock", 32'(state), 32'd3);
      oc_trip = 1'b1;
      repeat (2) step();
      rst = 1'b1;
      step();
      chk("t040_state", 32'(state), 32'd0);
      chk("t040_fault", 32'(fault), 32'd0);
      chk("t040_en", 32'({enA, enB}), 32'd0);
      rst = 1'b0; oc_trip = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) req_a = ~req_a;
         if ($urandom_range(0, 19) == 0) req_b = ~req_b;
         if (oc_left == 0) begin
            oc_trip = ($urandom_range(0, 3) == 0);
            oc_left = $urandom_range(1, 9);
         end
         oc_left--;
         clear_fault = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 599) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
